// File: rtl/clause_array_loader.sv
// Clause array loader: streams clause words into the array's literal cells one
// row per cycle, zero-fills the unused rows, and streams rows back out for
// write-back of a bin. One FSM serves both directions.
//
// Ports:
//   clk, rst              clock; synchronous active-low reset
//   start_load_i          pulse: load nb_c_i clauses, then zero-fill the rest
//   start_store_i         pulse: read back nb_c_i clauses
//   nb_c_i                clause count, sampled on an accepted start
//   busy_o, done_o        busy in every non-IDLE state; one-cycle completion pulse
//   clause_in_*           valid/ready input stream of clause words
//   wr_row_o, lit_row_o   one-hot row write strobe and literal bus to the cells
//   lit_rows_i            lit_o of every cell, row r at slice r*2*NUM_V
//   clause_out_*          valid/ready read-back stream with row index
module clause_array_loader #(
  parameter int unsigned NUM_C   = 8,
  parameter int unsigned NUM_V   = 8,
  parameter int unsigned WIDTH_C = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_load_i,
  input  logic                       start_store_i,
  input  logic [WIDTH_C-1:0]         nb_c_i,
  output logic                       busy_o,
  output logic                       done_o,
  input  logic                       clause_in_valid_i,
  output logic                       clause_in_ready_o,
  input  logic [2*NUM_V-1:0]         clause_in_data_i,
  output logic [NUM_C-1:0]           wr_row_o,
  output logic [2*NUM_V-1:0]         lit_row_o,
  input  logic [NUM_C*2*NUM_V-1:0]   lit_rows_i,
  output logic                       clause_out_valid_o,
  input  logic                       clause_out_ready_i,
  output logic [2*NUM_V-1:0]         clause_out_data_o,
  output logic [WIDTH_C-1:0]         clause_out_cid_o
);

  localparam int unsigned ROW_W = 2 * NUM_V;
  localparam logic [WIDTH_C-1:0] NUM_C_W  = WIDTH_C'(NUM_C);
  localparam logic [WIDTH_C-1:0] LAST_ROW = WIDTH_C'(NUM_C - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, STORE, DONE} state_t;

  state_t             state;
  logic [WIDTH_C-1:0] cnt;
  logic [WIDTH_C-1:0] n_tgt;

  logic [WIDTH_C-1:0] n_req_c;
  logic [WIDTH_C-1:0] cnt_inc_c;
  logic [NUM_C-1:0]   cnt_onehot_c;
  logic [WIDTH_C-1:0] sel_idx_c;
  logic [ROW_W-1:0]   sel_row_c;

  // Requested count clamped to the array height
  assign n_req_c      = (nb_c_i > NUM_C_W) ? NUM_C_W : nb_c_i;
  assign cnt_inc_c    = cnt + WIDTH_C'(1);
  assign cnt_onehot_c = NUM_C'(1) << cnt;

  // Row to present next: row 0 when a store starts, else the row after cnt
  assign sel_idx_c = (state == STORE) ? cnt_inc_c : '0;

  // Read-back row mux; an index past the last row selects zero
  always_comb begin
    sel_row_c = '0;
    for (int r = 0; r < int'(NUM_C); r++) begin
      if (sel_idx_c == WIDTH_C'(r)) sel_row_c = lit_rows_i[r*ROW_W +: ROW_W];
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state              <= IDLE;
      cnt                <= '0;
      n_tgt              <= '0;
      busy_o             <= 1'b0;
      done_o             <= 1'b0;
      clause_in_ready_o  <= 1'b0;
      wr_row_o           <= '0;
      lit_row_o          <= '0;
      clause_out_valid_o <= 1'b0;
      clause_out_data_o  <= '0;
      clause_out_cid_o   <= '0;
    end else begin
      wr_row_o <= '0;
      done_o   <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          // Load takes priority when both starts arrive together
          if (start_load_i) begin
            n_tgt  <= n_req_c;
            busy_o <= 1'b1;
            if (n_req_c != '0) begin
              state             <= LOAD;
              clause_in_ready_o <= 1'b1;
            end else begin
              state <= CLEAR;
            end
          end else if (start_store_i) begin
            n_tgt  <= n_req_c;
            busy_o <= 1'b1;
            if (n_req_c != '0) begin
              state              <= STORE;
              clause_out_valid_o <= 1'b1;
              clause_out_data_o  <= sel_row_c;
              clause_out_cid_o   <= '0;
            end else begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end
        end
        LOAD: begin
          // Ready is high for the whole state, so valid alone is a handshake
          if (clause_in_valid_i) begin
            wr_row_o  <= cnt_onehot_c;
            lit_row_o <= clause_in_data_i;
            cnt       <= cnt_inc_c;
            if (cnt_inc_c == n_tgt) begin
              clause_in_ready_o <= 1'b0;
              if (n_tgt == NUM_C_W) begin
                state  <= DONE;
                done_o <= 1'b1;
              end else begin
                state <= CLEAR;
              end
            end
          end
        end
        CLEAR: begin
          // Zero literals make the remaining rows non-participating
          wr_row_o  <= cnt_onehot_c;
          lit_row_o <= '0;
          cnt       <= cnt_inc_c;
          if (cnt == LAST_ROW) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        STORE: begin
          // Data and cid hold while the consumer stalls
          if (clause_out_ready_i) begin
            if (cnt_inc_c == n_tgt) begin
              clause_out_valid_o <= 1'b0;
              state              <= DONE;
              done_o             <= 1'b1;
            end else begin
              cnt               <= cnt_inc_c;
              clause_out_data_o <= sel_row_c;
              clause_out_cid_o  <= cnt_inc_c;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clause_array_loader.sv
// Self-checking bench for clause_array_loader: randomized loads and stores
// checked cycle by cycle against a row-sequence model of the loader.
module tb_clause_array_loader;

  localparam int unsigned NUM_C   = 8;
  localparam int unsigned NUM_V   = 8;
  localparam int unsigned WIDTH_C = 4;
  localparam int unsigned ROW_W   = 2 * NUM_V;

  logic                     clk;
  logic                     rst;
  logic                     start_load;
  logic                     start_store;
  logic [WIDTH_C-1:0]       nb_c;
  logic                     busy;
  logic                     done;
  logic                     in_valid;
  logic                     in_ready;
  logic [ROW_W-1:0]         in_data;
  logic [NUM_C-1:0]         wr_row;
  logic [ROW_W-1:0]         lit_row;
  logic [NUM_C*ROW_W-1:0]   lit_rows;
  logic                     out_valid;
  logic                     out_ready;
  logic [ROW_W-1:0]         out_data;
  logic [WIDTH_C-1:0]       out_cid;

  int n_checks = 0;
  int n_pass   = 0;

  clause_array_loader #(.NUM_C(NUM_C), .NUM_V(NUM_V), .WIDTH_C(WIDTH_C)) dut (
    .clk                (clk),
    .rst                (rst),
    .start_load_i       (start_load),
    .start_store_i      (start_store),
    .nb_c_i             (nb_c),
    .busy_o             (busy),
    .done_o             (done),
    .clause_in_valid_i  (in_valid),
    .clause_in_ready_o  (in_ready),
    .clause_in_data_i   (in_data),
    .wr_row_o           (wr_row),
    .lit_row_o          (lit_row),
    .lit_rows_i         (lit_rows),
    .clause_out_valid_o (out_valid),
    .clause_out_ready_i (out_ready),
    .clause_out_data_o  (out_data),
    .clause_out_cid_o   (out_cid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NUM_C*ROW_W-1:0] rand_rows();
    logic [NUM_C*ROW_W-1:0] v;
    for (int i = 0; i < int'(NUM_C*ROW_W/32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b0; start_load = 1'b0; start_store = 1'b0; nb_c = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; lit_rows = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", in_ready); else n_pass++;
    n_checks++; if (wr_row !== '0) $display("FAIL reset_wr_row got=%h exp=0", wr_row); else n_pass++;
    n_checks++; if (lit_row !== '0) $display("FAIL reset_lit_row got=%h exp=0", lit_row); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_checks++; if (out_data !== '0) $display("FAIL reset_out_data got=%h exp=0", out_data); else n_pass++;
    n_checks++; if (out_cid !== '0) $display("FAIL reset_out_cid got=%h exp=0", out_cid); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got=%b exp=0", busy); else n_pass++;
  endtask

  // vmode: 0 valid held high, 1 valid toggling, 2 random valid
  task automatic test_load(input int nreq, input int vmode, input bit both, input bit fixed,
                           input string name);
    logic [ROW_W-1:0] words [NUM_C];
    logic [NUM_C-1:0] exp_wr, nxt_wr;
    logic [ROW_W-1:0] exp_lit, nxt_lit;
    bit exp_done, nxt_done, phase_load, finished, v, vtog;
    int n, acc, clr;
    n = (nreq > int'(NUM_C)) ? int'(NUM_C) : nreq;
    for (int i = 0; i < int'(NUM_C); i++) words[i] = ROW_W'($urandom);
    if (fixed) begin
      words[0] = 16'h0001; words[1] = 16'h0230; words[2] = 16'hFFFF;
    end
    @(negedge clk);
    start_load = 1'b1; start_store = both; nb_c = WIDTH_C'(nreq); in_valid = 1'b0;
    acc = 0; clr = n; phase_load = (n > 0); finished = 1'b0; vtog = 1'b0;
    exp_wr = '0; exp_lit = '0; exp_done = 1'b0;
    for (int cyc = 0; cyc < 64 && !finished; cyc++) begin
      @(negedge clk);
      start_load = 1'b0;
      start_store = ($urandom_range(3) == 0);
      nb_c = WIDTH_C'($urandom);
      n_checks++; if (busy !== 1'b1) $display("FAIL %s busy c%0d got=%b exp=1", name, cyc, busy); else n_pass++;
      n_checks++; if (done !== exp_done) $display("FAIL %s done c%0d got=%b exp=%b", name, cyc, done, exp_done); else n_pass++;
      n_checks++; if (in_ready !== phase_load) $display("FAIL %s ready c%0d got=%b exp=%b", name, cyc, in_ready, phase_load); else n_pass++;
      n_checks++; if (wr_row !== exp_wr) $display("FAIL %s wr_row c%0d got=%h exp=%h", name, cyc, wr_row, exp_wr); else n_pass++;
      if (exp_wr != '0) begin
        n_checks++; if (lit_row !== exp_lit) $display("FAIL %s lit_row c%0d got=%h exp=%h", name, cyc, lit_row, exp_lit); else n_pass++;
      end
      if (exp_done) finished = 1'b1;
      case (vmode)
        0:       v = 1'b1;
        1:       begin v = vtog; vtog = ~vtog; end
        default: v = ($urandom_range(1) == 1);
      endcase
      in_valid = v;
      in_data  = (phase_load && v) ? words[acc] : ROW_W'($urandom);
      nxt_wr = '0; nxt_lit = '0; nxt_done = 1'b0;
      if (phase_load) begin
        if (v) begin
          nxt_wr = NUM_C'(1) << acc; nxt_lit = words[acc]; acc++;
          if (acc == n) begin
            phase_load = 1'b0;
            if (n == int'(NUM_C)) nxt_done = 1'b1;
          end
        end
      end else if (clr < int'(NUM_C)) begin
        nxt_wr = NUM_C'(1) << clr; nxt_lit = '0; clr++;
        if (clr == int'(NUM_C)) nxt_done = 1'b1;
      end
      exp_wr = nxt_wr; exp_lit = nxt_lit; exp_done = nxt_done;
    end
    n_checks++; if (!finished) $display("FAIL %s timeout got=no_done exp=done", name); else n_pass++;
    @(negedge clk);
    start_load = 1'b0; start_store = 1'b0; in_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL %s end_busy got=%b exp=0", name, busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL %s end_done got=%b exp=0", name, done); else n_pass++;
    n_checks++; if (wr_row !== '0) $display("FAIL %s end_wr_row got=%h exp=0", name, wr_row); else n_pass++;
  endtask

  // smode: 0 ready held high, 1 three-cycle stall on row 1, 2 random ready
  task automatic test_store(input int nreq, input int smode, input string name);
    logic [ROW_W-1:0] snap;
    bit exp_valid, exp_done, finished, r;
    int n, cur, stall;
    n = (nreq > int'(NUM_C)) ? int'(NUM_C) : nreq;
    lit_rows = rand_rows();
    @(negedge clk);
    start_store = 1'b1; start_load = 1'b0; nb_c = WIDTH_C'(nreq); out_ready = 1'b0;
    cur = 0; stall = 0; finished = 1'b0;
    snap = lit_rows[0 +: ROW_W];
    exp_valid = (n > 0); exp_done = (n == 0);
    for (int cyc = 0; cyc < 64 && !finished; cyc++) begin
      @(negedge clk);
      start_store = 1'b0;
      start_load = ($urandom_range(3) == 0);
      nb_c = WIDTH_C'($urandom);
      n_checks++; if (busy !== 1'b1) $display("FAIL %s busy c%0d got=%b exp=1", name, cyc, busy); else n_pass++;
      n_checks++; if (done !== exp_done) $display("FAIL %s done c%0d got=%b exp=%b", name, cyc, done, exp_done); else n_pass++;
      n_checks++; if (out_valid !== exp_valid) $display("FAIL %s valid c%0d got=%b exp=%b", name, cyc, out_valid, exp_valid); else n_pass++;
      n_checks++; if (wr_row !== '0) $display("FAIL %s wr_row c%0d got=%h exp=0", name, cyc, wr_row); else n_pass++;
      if (exp_valid) begin
        n_checks++; if (out_cid !== WIDTH_C'(cur)) $display("FAIL %s cid c%0d got=%0d exp=%0d", name, cyc, out_cid, cur); else n_pass++;
        n_checks++; if (out_data !== snap) $display("FAIL %s data c%0d got=%h exp=%h", name, cyc, out_data, snap); else n_pass++;
      end
      if (exp_done) begin
        finished = 1'b1; exp_done = 1'b0;
      end
      // Array contents move every cycle; the presented row must not
      lit_rows = rand_rows();
      case (smode)
        0: r = 1'b1;
        1: begin
          r = !(cur == 1 && stall < 3);
          if (!r) stall++;
        end
        default: r = ($urandom_range(1) == 1);
      endcase
      out_ready = r;
      if (exp_valid && r) begin
        if (cur == n - 1) begin
          exp_valid = 1'b0; exp_done = 1'b1;
        end else begin
          cur++; snap = lit_rows[cur*ROW_W +: ROW_W];
        end
      end
    end
    n_checks++; if (!finished) $display("FAIL %s timeout got=no_done exp=done", name); else n_pass++;
    @(negedge clk);
    start_load = 1'b0; start_store = 1'b0; out_ready = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL %s end_busy got=%b exp=0", name, busy); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL %s end_valid got=%b exp=0", name, out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    start_load = 1'b1; nb_c = WIDTH_C'(5); in_valid = 1'b0;
    @(negedge clk);
    start_load = 1'b0; in_valid = 1'b1; in_data = 16'hA5C3;
    @(negedge clk);
    n_checks++; if (wr_row !== 8'h01) $display("FAIL rst_mid first_beat got=%h exp=01", wr_row); else n_pass++;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_mid done got=%b exp=0", done); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_mid ready got=%b exp=0", in_ready); else n_pass++;
    n_checks++; if (wr_row !== '0) $display("FAIL rst_mid wr_row got=%h exp=0", wr_row); else n_pass++;
    n_checks++; if (lit_row !== '0) $display("FAIL rst_mid lit_row got=%h exp=0", lit_row); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid out_valid got=%b exp=0", out_valid); else n_pass++;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_checks++; if (done !== 1'b0) $display("FAIL rst_mid late_done got=%b exp=0", done); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid late_busy got=%b exp=0", busy); else n_pass++;
    end
    test_load(4, 2, 1'b0, 1'b0, "load_after_rst");
  endtask

  initial begin
    test_reset();
    test_load(3, 0, 1'b0, 1'b1, "load3_fixed");
    test_load(2, 1, 1'b0, 1'b0, "load2_toggle");
    test_load(0, 2, 1'b0, 1'b0, "load0");
    test_load(12, 0, 1'b0, 1'b0, "load12");
    test_load(8, 2, 1'b0, 1'b0, "load8_rand");
    test_load(5, 0, 1'b1, 1'b0, "load_both_starts");
    test_store(4, 1, "store4_stall");
    test_store(0, 0, "store0");
    test_store(12, 2, "store12_rand");
    test_store(8, 0, "store8");
    test_reset_mid_load();
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(1) == 1) test_load(int'($urandom_range(15)), 2, 1'b0, 1'b0, "rand_load");
      else test_store(int'($urandom_range(15)), 2, "rand_store");
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
